// File: rtl/fir_output_checker.sv
// fir_output_checker: compares a signed FIR result stream against an expected-sample ROM,
// counting mismatches (with tolerance and pipeline-fill skip) and raising sticky done/pass.
module fir_output_checker #(
  parameter int DATA_W      = 16,
  parameter int NUM_SAMPLES = 16,
  parameter int LATENCY     = 0,
  parameter int TOL         = 0,
  parameter logic [NUM_SAMPLES*DATA_W-1:0] ROM_INIT = '0
) (
  input  logic                     system1000,
  input  logic                     system1000_rst,
  input  logic signed [DATA_W-1:0] arg,
  input  logic                     arg_valid,
  output logic                     done,
  output logic                     pass,
  output logic [15:0]              err_count,
  output logic [15:0]              first_err_idx,
  output logic                     mismatch,
  output logic [15:0]              sample_idx
);
  typedef enum logic [1:0] {S_SKIP, S_CHECK, S_DONE} state_t;
  localparam state_t            S_INIT    = (LATENCY > 0) ? S_SKIP : S_CHECK;
  localparam logic [15:0]       LAST      = 16'(NUM_SAMPLES - 1);
  localparam logic [15:0]       SKIP_LAST = 16'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [DATA_W:0]   TOL_V     = (DATA_W + 1)'(TOL);
  localparam int                AW        = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  state_t              r_state, w_state_n;
  logic [15:0]         r_skip, w_skip_n;
  logic [15:0]         r_err, w_err_n;
  logic [15:0]         r_first, w_first_n;
  logic [15:0]         r_idx, w_idx_n;
  logic                r_mis, w_mis_n;
  logic                r_done, w_done_n;
  logic                r_pass, w_pass_n;
  logic [DATA_W-1:0]   w_mem [2**AW];
  logic [DATA_W-1:0]   w_rom;
  logic signed [DATA_W:0] w_diff;
  logic [DATA_W:0]     w_abs;
  logic                w_miss;
  // ROM padded to a power of two so the address is exactly AW bits wide
  for (genvar g = 0; g < 2**AW; g++) begin : g_mem
    if (g < NUM_SAMPLES) begin : g_used
      assign w_mem[g] = ROM_INIT[g*DATA_W +: DATA_W];
    end else begin : g_pad
      assign w_mem[g] = '0;
    end
  end
  assign w_rom  = w_mem[r_idx[AW-1:0]];
  // one extra bit keeps full-scale opposite-sign differences from wrapping
  assign w_diff = {arg[DATA_W-1], arg} - {w_rom[DATA_W-1], w_rom};
  assign w_abs  = w_diff[DATA_W] ? -w_diff : w_diff;
  assign w_miss = w_abs > TOL_V;
  always_comb begin
    w_state_n = r_state;
    w_skip_n  = r_skip;
    w_err_n   = r_err;
    w_first_n = r_first;
    w_idx_n   = r_idx;
    w_mis_n   = 1'b0;
    w_done_n  = r_done;
    w_pass_n  = r_pass;
    if (arg_valid && r_state == S_SKIP) begin
      w_skip_n  = r_skip + 16'd1;
      w_state_n = (r_skip == SKIP_LAST) ? S_CHECK : S_SKIP;
    end else if (arg_valid && r_state == S_CHECK) begin
      w_mis_n   = w_miss;
      w_err_n   = (w_miss && r_err != 16'hFFFF) ? r_err + 16'd1 : r_err;
      w_first_n = (w_miss && r_first == 16'hFFFF) ? r_idx : r_first;
      w_idx_n   = r_idx + 16'd1;
      if (r_idx == LAST) begin
        w_state_n = S_DONE;
        w_done_n  = 1'b1;
        w_pass_n  = (w_err_n == 16'd0);
      end
    end
  end
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      r_state <= S_INIT;
      r_skip  <= '0;
      r_err   <= '0;
      r_first <= 16'hFFFF;
      r_idx   <= '0;
      r_mis   <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_skip  <= w_skip_n;
      r_err   <= w_err_n;
      r_first <= w_first_n;
      r_idx   <= w_idx_n;
      r_mis   <= w_mis_n;
      r_done  <= w_done_n;
      r_pass  <= w_pass_n;
    end
  end
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_err;
  assign first_err_idx = r_first;
  assign mismatch      = r_mis;
  assign sample_idx    = r_idx;
endmodule

// File: tb/tb_fir_output_checker.sv
// tb_fir_output_checker: directed, table-driven bench over four checker configurations
// (plain, pipeline skip, tolerance, single full-scale sample) sharing one stimulus bus.
module tb_fir_output_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] arg = '0;
  logic valid = 1'b0;
  logic [3:0] done, pass, mis;
  logic [15:0] err [4];
  logic [15:0] first [4];
  logic [15:0] idx [4];
  int n_pass = 0;
  int n_tot = 0;
  always #5 clk = ~clk;
  function automatic logic [255:0] ramp();
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = 16'(i);
    return r;
  endfunction
  fir_output_checker #(.NUM_SAMPLES(16), .LATENCY(0), .TOL(0), .ROM_INIT(ramp())) u0 (
    .system1000(clk), .system1000_rst(rst), .arg(arg), .arg_valid(valid), .done(done[0]),
    .pass(pass[0]), .err_count(err[0]), .first_err_idx(first[0]), .mismatch(mis[0]), .sample_idx(idx[0]));
  fir_output_checker #(.NUM_SAMPLES(16), .LATENCY(3), .TOL(0), .ROM_INIT(ramp())) u1 (
    .system1000(clk), .system1000_rst(rst), .arg(arg), .arg_valid(valid), .done(done[1]),
    .pass(pass[1]), .err_count(err[1]), .first_err_idx(first[1]), .mismatch(mis[1]), .sample_idx(idx[1]));
  fir_output_checker #(.NUM_SAMPLES(4), .LATENCY(0), .TOL(2),
    .ROM_INIT({16'd0, 16'd0, 16'd100, 16'd100})) u2 (
    .system1000(clk), .system1000_rst(rst), .arg(arg), .arg_valid(valid), .done(done[2]),
    .pass(pass[2]), .err_count(err[2]), .first_err_idx(first[2]), .mismatch(mis[2]), .sample_idx(idx[2]));
  fir_output_checker #(.NUM_SAMPLES(1), .LATENCY(0), .TOL(0), .ROM_INIT(16'h8000)) u3 (
    .system1000(clk), .system1000_rst(rst), .arg(arg), .arg_valid(valid), .done(done[3]),
    .pass(pass[3]), .err_count(err[3]), .first_err_idx(first[3]), .mismatch(mis[3]), .sample_idx(idx[3]));
  typedef struct {
    logic v; logic [15:0] a; logic m; logic [15:0] e; logic [15:0] f; logic [15:0] x; logic d; logic p;
  } vec_t;
  vec_t tv [21];
  function automatic vec_t mk(logic v, logic [15:0] a, logic m, logic [15:0] e, logic [15:0] f,
                              logic [15:0] x, logic d, logic p);
    vec_t t;
    t.v = v; t.a = a; t.m = m; t.e = e; t.f = f; t.x = x; t.d = d; t.p = p;
    return t;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask
  task automatic drive(input logic v, input logic [15:0] a);
    valid = v;
    arg = a;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic chk_all(input string name, input int d, input logic m, input logic [15:0] e,
                         input logic [15:0] f, input logic [15:0] x, input logic dn, input logic p);
    chk({name, ".mismatch"}, mis[d], m);
    chk({name, ".err_count"}, err[d], e);
    chk({name, ".first_err_idx"}, first[d], f);
    chk({name, ".sample_idx"}, idx[d], x);
    chk({name, ".done"}, done[d], dn);
    chk({name, ".pass"}, pass[d], p);
  endtask
  always @(negedge clk)
    for (int d = 0; d < 4; d++) if (pass[d] && !done[d]) chk($sformatf("pass_without_done%0d", d), 1, 0);
  initial begin
    tv[0]  = mk(1, 0, 0, 0, 16'hFFFF, 1, 0, 0);
    tv[1]  = mk(1, 1, 0, 0, 16'hFFFF, 2, 0, 0);
    tv[2]  = mk(1, 2, 0, 0, 16'hFFFF, 3, 0, 0);
    tv[3]  = mk(0, 77, 0, 0, 16'hFFFF, 3, 0, 0);
    tv[4]  = mk(0, 77, 0, 0, 16'hFFFF, 3, 0, 0);
    tv[5]  = mk(1, 3, 0, 0, 16'hFFFF, 4, 0, 0);
    tv[6]  = mk(1, 4, 0, 0, 16'hFFFF, 5, 0, 0);
    tv[7]  = mk(1, 99, 1, 1, 5, 6, 0, 0);
    tv[8]  = mk(1, 6, 0, 1, 5, 7, 0, 0);
    tv[9]  = mk(1, 7, 0, 1, 5, 8, 0, 0);
    tv[10] = mk(1, 8, 0, 1, 5, 9, 0, 0);
    tv[11] = mk(1, 16'hFFFD, 1, 2, 5, 10, 0, 0);
    tv[12] = mk(0, 9, 0, 2, 5, 10, 0, 0);
    tv[13] = mk(1, 10, 0, 2, 5, 11, 0, 0);
    tv[14] = mk(1, 11, 0, 2, 5, 12, 0, 0);
    tv[15] = mk(1, 12, 0, 2, 5, 13, 0, 0);
    tv[16] = mk(1, 13, 0, 2, 5, 14, 0, 0);
    tv[17] = mk(1, 14, 0, 2, 5, 15, 0, 0);
    tv[18] = mk(1, 15, 0, 2, 5, 16, 1, 0);
    tv[19] = mk(1, 0, 0, 2, 5, 16, 1, 0);
    tv[20] = mk(1, 99, 0, 2, 5, 16, 1, 0);
    // clean ramp: done exactly 16 samples after release, then ignores further input
    do_reset();
    chk_all("reset_u0", 0, 0, 0, 16'hFFFF, 0, 0, 0);
    chk_all("reset_u1", 1, 0, 0, 16'hFFFF, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      drive(1, 16'(i));
      if (i == 14) chk("clean.done_early", done[0], 0);
    end
    chk_all("clean", 0, 0, 0, 16'hFFFF, 16, 1, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'h1234);
      chk_all("clean_after_done", 0, 0, 0, 16'hFFFF, 16, 1, 1);
    end
    // errors at 5 and 9 with arg_valid gaps
    do_reset();
    foreach (tv[k]) begin
      drive(tv[k].v, tv[k].a);
      chk_all($sformatf("tv%0d", k), 0, tv[k].m, tv[k].e, tv[k].f, tv[k].x, tv[k].d, tv[k].p);
    end
    // pipeline skip of three garbage samples
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 16'h7FFF);
    chk_all("skip", 1, 0, 0, 16'hFFFF, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      drive(1, 16'(i));
      chk("skip.mismatch", mis[1], 0);
      if (i == 14) chk("skip.done_early", done[1], 0);
    end
    chk_all("skip_end", 1, 0, 0, 16'hFFFF, 16, 1, 1);
    // tolerance: 102 and 2/-2 within 2, 97 outside
    do_reset();
    drive(1, 16'd102);
    chk("tol.102", mis[2], 0);
    drive(1, 16'd97);
    chk("tol.97", mis[2], 1);
    drive(1, 16'd2);
    chk("tol.2", mis[2], 0);
    drive(1, 16'hFFFE);
    chk_all("tol_end", 2, 0, 1, 1, 4, 1, 0);
    // single-sample ROM holding -32768
    do_reset();
    chk("fs.done_reset", done[3], 0);
    drive(1, 16'h7FFF);
    chk_all("fullscale_pos", 3, 1, 1, 0, 1, 1, 0);
    do_reset();
    drive(1, 16'h8000);
    chk_all("fullscale_eq", 3, 0, 0, 16'hFFFF, 1, 1, 1);
    // reset mid-run aborts and restarts from sample 0
    do_reset();
    for (int i = 0; i < 8; i++) drive(1, (i == 2 || i == 6) ? 16'd50 : 16'(i));
    chk_all("midrun", 0, 0, 2, 2, 8, 0, 0);
    rst = 1'b1;
    valid = 1'b1;
    arg = 16'd50;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all("midrun_reset", 0, 0, 0, 16'hFFFF, 0, 0, 0);
    for (int i = 0; i < 16; i++) drive(1, 16'(i));
    chk_all("replay", 0, 0, 0, 16'hFFFF, 16, 1, 1);
    valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
